// File: rtl/fifo_wr_arbiter_if.sv
// Write-port sharing bundle: N_REQ valid/ready producers on one side,
// a single Synchronous_FIFO write port plus status on the other.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_w_en;
    logic [DATA_W-1:0]       fifo_data_in;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;
    logic [15:0]             stall_cnt;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_w_en, fifo_data_in, grant_id, busy, stall_cnt
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_w_en, fifo_data_in, grant_id, busy, stall_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers;
// a grant lasts up to BURST beats and full backpressure reaches only the owner.
module fifo_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int BURST  = 4,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input logic              clk,
    input logic              rst_n,
    fifo_wr_arbiter_if.master bus
);

    localparam int          CNT_W  = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int unsigned NREQ_U = N_REQ;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   scan_idx;
    logic              any_valid;
    logic              own_valid;
    logic              accept;
    logic              last_beat;
    logic [ID_W-1:0]   next_ptr;

    logic [N_REQ-1:0]  ready;
    logic              w_en;
    logic [DATA_W-1:0] data_out;
    logic [ID_W-1:0]   gid;
    logic              busy;

    // First valid requester at or after rr_ptr, wrapping circularly.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            scan_idx = ID_W'((32'(rr_ptr_q) + i) % NREQ_U);
            if (!any_valid && bus.req_valid[scan_idx]) begin
                winner    = scan_idx;
                any_valid = 1'b1;
            end
        end
    end

    assign own_valid = bus.req_valid[owner_q];
    assign accept    = (state_q == HOLD) && own_valid && !bus.fifo_full;
    assign last_beat = (beat_cnt_q == CNT_W'(BURST - 1));
    assign next_ptr  = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d    = HOLD;
                    owner_d    = winner;
                    beat_cnt_d = '0;
                end
            end
            HOLD: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (own_valid && bus.fifo_full && (stall_cnt_q != 16'hFFFF)) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
                // Dropping valid releases the grant even while the FIFO is full.
                if ((accept && last_beat) || !own_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready    = '0;
        w_en     = 1'b0;
        data_out = '0;
        gid      = '0;
        busy     = 1'b0;
        if (state_q == HOLD) begin
            ready[owner_q] = !bus.fifo_full;
            w_en           = accept;
            data_out       = bus.req_data[owner_q*DATA_W +: DATA_W];
            gid            = owner_q;
            busy           = 1'b1;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_w_en    = w_en;
    assign bus.fifo_data_in = data_out;
    assign bus.grant_id     = gid;
    assign bus.busy         = busy;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule
